// File: rtl/pipe_pkg.sv
// Shared definitions for the pipelined CPU execute stage: ALU and MDU
// operation codes, the multiply/divide unit state type and a small decode helper.
package pipe_pkg;

  // ALU operation codes carried on ealuc
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_LUI  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SLT  = 4'd9;
  localparam logic [3:0] ALU_SLTU = 4'd10;

  // Multiply/divide operation codes carried on emdop
  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MFHI  = 3'd5;
  localparam logic [2:0] MD_MFLO  = 3'd6;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_t;

  // True for the four ops that launch an iterative multiply or divide
  function automatic logic is_mdu_start(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/pipe_mdu.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Multiplies by shift-add and divides by restoring subtraction on operand
// magnitudes, one step per cycle for XLEN cycles, then applies sign fix-up.
module pipe_mdu
  import pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN);

  mdu_state_t      state;
  logic [CW-1:0]   count;
  logic [2:0]      op_q;
  logic            sign_a;
  logic            sign_b;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] work;
  logic [XLEN-1:0] mcand;

  logic            start_signed;
  logic            start_mul;
  logic            start_sa;
  logic            start_sb;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;

  logic            is_mul;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;
  logic [XLEN-1:0] step_acc;
  logic [XLEN-1:0] step_work;

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fin_hi;
  logic [XLEN-1:0]   fin_lo;

  assign busy = (state == MDU_BUSY);

  // Operand magnitudes and signs captured when an operation is launched
  always_comb begin
    start_signed = (op == MD_MULT) || (op == MD_DIV);
    start_mul    = (op == MD_MULT) || (op == MD_MULTU);
    start_sa     = start_signed & a[XLEN-1];
    start_sb     = start_signed & b[XLEN-1];
    mag_a        = start_sa ? (-a) : a;
    mag_b        = start_sb ? (-b) : b;
  end

  // One shift-add (multiply) or restoring-subtract (divide) iteration
  always_comb begin
    is_mul    = (op_q == MD_MULT) || (op_q == MD_MULTU);
    mul_sum   = {1'b0, acc} + {1'b0, (work[0] ? mcand : {XLEN{1'b0}})};
    div_shift = {acc, work[XLEN-1]};
    div_diff  = div_shift - {1'b0, mcand};
    if (is_mul) begin
      step_acc  = mul_sum[XLEN:1];
      step_work = {mul_sum[0], work[XLEN-1:1]};
    end else if (!div_diff[XLEN]) begin
      step_acc  = div_diff[XLEN-1:0];
      step_work = {work[XLEN-2:0], 1'b1};
    end else begin
      step_acc  = div_shift[XLEN-1:0];
      step_work = {work[XLEN-2:0], 1'b0};
    end
  end

  // Sign fix-up of the final iteration; a zero divisor leaves the dividend
  // magnitude in the remainder, so only the quotient needs overriding
  always_comb begin
    prod   = {step_acc, step_work};
    quo    = (sign_a ^ sign_b) ? (-step_work) : step_work;
    rem    = sign_a ? (-step_acc) : step_acc;
    fin_hi = rem;
    fin_lo = quo;
    if (is_mul) begin
      {fin_hi, fin_lo} = (sign_a ^ sign_b) ? (-prod) : prod;
    end else if (mcand == {XLEN{1'b0}}) begin
      fin_lo = {XLEN{1'b1}};
    end
  end

  // IDLE/BUSY sequencer: launch, iterate XLEN times, then commit HI/LO
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= MDU_IDLE;
      count  <= '0;
      op_q   <= MD_NONE;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      acc    <= '0;
      work   <= '0;
      mcand  <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        MDU_IDLE: begin
          if (start) begin
            op_q   <= op;
            sign_a <= start_sa;
            sign_b <= start_sb;
            acc    <= '0;
            work   <= start_mul ? mag_b : mag_a;
            mcand  <= start_mul ? mag_a : mag_b;
            count  <= CW'(XLEN - 1);
            state  <= MDU_BUSY;
          end
        end
        MDU_BUSY: begin
          acc  <= step_acc;
          work <= step_work;
          if (count == '0) begin
            hi    <= fin_hi;
            lo    <= fin_lo;
            state <= MDU_IDLE;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pipe_exe_mdu.sv
// Execute stage: ALU, link handling, MDU front end, stall generation and
// the EX/MEM pipeline register.
// Optional macro PIPE_EXE_OVF_TRAP_EN adds the moverf output, flagging signed
// overflow on ADD/SUB and suppressing that instruction's register write.
module pipe_exe_mdu
  import pipe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RW   = 5,
  parameter int SW   = $clog2(XLEN)
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            ein_valid,
  input  logic [XLEN-1:0] ea,
  input  logic [XLEN-1:0] eb,
  input  logic [XLEN-1:0] eimm,
  input  logic [XLEN-1:0] epc4,
  input  logic [RW-1:0]   ern0,
  input  logic [3:0]      ealuc,
  input  logic            ealuimm,
  input  logic            eshift,
  input  logic            ejal,
  input  logic [2:0]      emdop,
  output logic            estall,
  output logic            mvalid,
  output logic [XLEN-1:0] malu,
  output logic [RW-1:0]   mrn
`ifdef PIPE_EXE_OVF_TRAP_EN
  ,
  output logic            moverf
`endif
);

  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] alu_res;
  logic            mdu_busy;
  logic            mdu_start;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic            nx_valid;
  logic [XLEN-1:0] nx_alu;
  logic [RW-1:0]   nx_rn;
`ifdef PIPE_EXE_OVF_TRAP_EN
  logic            ovf;
  logic            nx_ovf;
`endif

  assign alu_a     = eshift ? {{(XLEN-SW){1'b0}}, eimm[6+SW-1:6]} : ea;
  assign alu_b     = ealuimm ? eimm : eb;
  assign shamt     = alu_a[SW-1:0];
  assign estall    = ein_valid & mdu_busy & (emdop != MD_NONE);
  assign mdu_start = ein_valid & ~mdu_busy & is_mdu_start(emdop);

  pipe_mdu #(
    .XLEN(XLEN)
  ) u_mdu (
    .clock (clock),
    .resetn(resetn),
    .start (mdu_start),
    .op    (emdop),
    .a     (ea),
    .b     (eb),
    .busy  (mdu_busy),
    .hi    (hi),
    .lo    (lo)
  );

  // ALU result selection; undefined op codes produce zero
  always_comb begin
    alu_res = '0;
    case (ealuc)
      ALU_ADD:  alu_res = alu_a + alu_b;
      ALU_SUB:  alu_res = alu_a - alu_b;
      ALU_AND:  alu_res = alu_a & alu_b;
      ALU_OR:   alu_res = alu_a | alu_b;
      ALU_XOR:  alu_res = alu_a ^ alu_b;
      ALU_LUI:  alu_res = alu_b << (XLEN / 2);
      ALU_SLL:  alu_res = alu_b << shamt;
      ALU_SRL:  alu_res = alu_b >> shamt;
      ALU_SRA:  alu_res = $signed(alu_b) >>> shamt;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (alu_a < alu_b)};
      default:  alu_res = '0;
    endcase
  end

`ifdef PIPE_EXE_OVF_TRAP_EN
  // Signed overflow detection for ADD and SUB
  always_comb begin
    ovf = 1'b0;
    if (ealuc == ALU_ADD) begin
      ovf = (alu_a[XLEN-1] == alu_b[XLEN-1]) && (alu_res[XLEN-1] != alu_a[XLEN-1]);
    end else if (ealuc == ALU_SUB) begin
      ovf = (alu_a[XLEN-1] != alu_b[XLEN-1]) && (alu_res[XLEN-1] != alu_a[XLEN-1]);
    end
  end
`endif

  // Next EX/MEM contents: bubble when invalid or stalled, otherwise the
  // MDU read, link address or ALU result; MDU launches retire with no write
  always_comb begin
    nx_valid = 1'b0;
    nx_alu   = '0;
    nx_rn    = '0;
`ifdef PIPE_EXE_OVF_TRAP_EN
    nx_ovf   = 1'b0;
`endif
    if (ein_valid && !estall) begin
      nx_valid = 1'b1;
      if (is_mdu_start(emdop)) begin
        nx_rn = '0;
      end else if (emdop == MD_MFHI) begin
        nx_alu = hi;
        nx_rn  = ern0;
      end else if (emdop == MD_MFLO) begin
        nx_alu = lo;
        nx_rn  = ern0;
      end else if (ejal) begin
        nx_alu = epc4 + XLEN'(4);
        nx_rn  = {RW{1'b1}};
      end else begin
        nx_alu = alu_res;
        nx_rn  = ern0;
`ifdef PIPE_EXE_OVF_TRAP_EN
        if (ovf) begin
          nx_ovf = 1'b1;
          nx_rn  = '0;
        end
`endif
      end
    end
  end

  // EX/MEM pipeline register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mvalid <= 1'b0;
      malu   <= '0;
      mrn    <= '0;
`ifdef PIPE_EXE_OVF_TRAP_EN
      moverf <= 1'b0;
`endif
    end else begin
      mvalid <= nx_valid;
      malu   <= nx_alu;
      mrn    <= nx_rn;
`ifdef PIPE_EXE_OVF_TRAP_EN
      moverf <= nx_ovf;
`endif
    end
  end

endmodule

// File: tb/tb_pipe_exe_mdu.sv
// Self-checking bench for pipe_exe_mdu (XLEN=32): directed steps followed by
// randomized traffic, each step compared against an arithmetic reference model.
// Honours PIPE_EXE_OVF_TRAP_EN for the moverf output.
module tb_pipe_exe_mdu;
  import pipe_pkg::*;

  localparam int XLEN = 32;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        ein_valid = 1'b0;
  logic [31:0] ea = '0, eb = '0, eimm = '0, epc4 = '0;
  logic [4:0]  ern0 = '0;
  logic [3:0]  ealuc = '0;
  logic        ealuimm = 1'b0, eshift = 1'b0, ejal = 1'b0;
  logic [2:0]  emdop = '0;
  logic        estall, mvalid;
  logic [31:0] malu;
  logic [4:0]  mrn;
`ifdef PIPE_EXE_OVF_TRAP_EN
  logic        moverf;
`endif

  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int          m_left = 0;
  logic        obs_stall = 1'b0;

  pipe_exe_mdu #(.XLEN(XLEN), .RW(5)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .ein_valid(ein_valid),
    .ea       (ea),
    .eb       (eb),
    .eimm     (eimm),
    .epc4     (epc4),
    .ern0     (ern0),
    .ealuc    (ealuc),
    .ealuimm  (ealuimm),
    .eshift   (eshift),
    .ejal     (ejal),
    .emdop    (emdop),
    .estall   (estall),
    .mvalid   (mvalid),
    .malu     (malu),
    .mrn      (mrn)
`ifdef PIPE_EXE_OVF_TRAP_EN
    ,
    .moverf   (moverf)
`endif
  );

  // Free-running clock
  always #5 clock = ~clock;

  // Time limit so the bench always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      ALU_ADD:  return 32'(sa + sb);
      ALU_SUB:  return 32'(sa - sb);
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_LUI:  return 32'(longint'(b) * 65536);
      ALU_SLL:  return 32'(longint'(b) * (longint'(1) << a[4:0]));
      ALU_SRL:  return 32'(longint'(b) / (longint'(1) << a[4:0]));
      ALU_SRA:  return 32'(sb >>> a[4:0]);
      ALU_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLTU: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic ref_ovf(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint r;
    if (op == ALU_ADD) r = longint'($signed(a)) + longint'($signed(b));
    else if (op == ALU_SUB) r = longint'($signed(a)) - longint'($signed(b));
    else return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  // HI/LO outcome of a multiply or divide computed with wide arithmetic
  task automatic ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MD_MULT:  begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      MD_MULTU: begin up = {32'd0, a} * {32'd0, b}; m_hi = up[63:32]; m_lo = up[31:0]; end
      MD_DIV: begin
        if (b == 32'd0) begin m_lo = 32'hFFFFFFFF; m_hi = a; end
        else begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      end
      MD_DIVU: begin
        if (b == 32'd0) begin m_lo = 32'hFFFFFFFF; m_hi = a; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
      default: ;
    endcase
  endtask

  // Drive one instruction, check the stall it raises, clock it through and
  // check the EX/MEM register against the model
  task automatic applyStimulus(input logic v, input logic [3:0] alu, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc4,
                               input logic [4:0] rn, input logic aluimm, input logic shift,
                               input logic jal, input logic [2:0] md);
    logic exp_stall, exp_valid, start, care_alu;
    logic [31:0] exp_alu, a_side, b_side;
    logic [4:0] exp_rn;
    logic exp_ovf;
    ein_valid = v; ealuc = alu; ea = a; eb = b; eimm = imm; epc4 = pc4;
    ern0 = rn; ealuimm = aluimm; eshift = shift; ejal = jal; emdop = md;
    #1;
    exp_stall = v && (m_left > 0) && (md != MD_NONE);
    obs_stall = estall;
    checkOutput("estall", {63'd0, estall}, {63'd0, exp_stall});
    exp_valid = 1'b0; exp_alu = '0; exp_rn = '0; exp_ovf = 1'b0; start = 1'b0; care_alu = 1'b1;
    a_side = shift ? {27'd0, imm[10:6]} : a;
    b_side = aluimm ? imm : b;
    if (v && !exp_stall) begin
      exp_valid = 1'b1;
      if (md inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU}) begin
        start = 1'b1; care_alu = 1'b0; exp_rn = '0;
      end else if (md == MD_MFHI) begin
        exp_alu = m_hi; exp_rn = rn;
      end else if (md == MD_MFLO) begin
        exp_alu = m_lo; exp_rn = rn;
      end else if (jal) begin
        exp_alu = pc4 + 32'd4; exp_rn = 5'd31;
      end else begin
        exp_alu = ref_alu(alu, a_side, b_side); exp_rn = rn;
`ifdef PIPE_EXE_OVF_TRAP_EN
        exp_ovf = ref_ovf(alu, a_side, b_side);
        if (exp_ovf) exp_rn = '0;
`endif
      end
    end
    @(posedge clock);
    #1;
    if (start) begin
      ref_mdu(md, a, b);
      m_left = XLEN;
    end else if (m_left > 0) begin
      m_left--;
    end
    checkOutput("mvalid", {63'd0, mvalid}, {63'd0, exp_valid});
    checkOutput("mrn", {59'd0, mrn}, {59'd0, exp_rn});
    if (care_alu) checkOutput("malu", {32'd0, malu}, {32'd0, exp_alu});
`ifdef PIPE_EXE_OVF_TRAP_EN
    checkOutput("moverf", {63'd0, moverf}, {63'd0, exp_ovf});
`endif
  endtask

  task automatic alu_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rn);
    applyStimulus(1'b1, op, a, b, 32'd0, 32'd0, rn, 1'b0, 1'b0, 1'b0, MD_NONE);
  endtask

  task automatic mdu_op(input logic [2:0] md, input logic [31:0] a, input logic [31:0] b);
    applyStimulus(1'b1, ALU_ADD, a, b, 32'd0, 32'd0, 5'd9, 1'b0, 1'b0, 1'b0, md);
  endtask

  // Keep issuing an HI/LO read until it stops stalling; n counts stall cycles
  task automatic drain(input logic [2:0] md, output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      mdu_op(md, 32'd0, 32'd0);
      if (obs_stall) n++;
      else break;
    end
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    logic [31:0] ra, rb;
    logic [2:0] rmd;

    // Reset state with an MFHI waiting at the input
    ein_valid = 1'b1; emdop = MD_MFHI;
    #12;
    checkOutput("reset_mvalid", {63'd0, mvalid}, 64'd0);
    checkOutput("reset_malu", {32'd0, malu}, 64'd0);
    checkOutput("reset_mrn", {59'd0, mrn}, 64'd0);
    checkOutput("reset_estall", {63'd0, estall}, 64'd0);
`ifdef PIPE_EXE_OVF_TRAP_EN
    checkOutput("reset_moverf", {63'd0, moverf}, 64'd0);
`endif
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;

    alu_op(ALU_ADD, 32'd7, 32'd5, 5'd3);
    checkOutput("add_malu", {32'd0, malu}, 64'd12);
    checkOutput("add_mrn", {59'd0, mrn}, 64'd3);

    applyStimulus(1'b1, ALU_SRA, 32'd0, 32'h80000000, 32'd4 << 6, 32'd0, 5'd6, 1'b0, 1'b1, 1'b0, MD_NONE);
    checkOutput("sra_malu", {32'd0, malu}, 64'hF8000000);

    applyStimulus(1'b1, ALU_ADD, 32'd1, 32'd1, 32'd0, 32'h100, 5'd0, 1'b0, 1'b0, 1'b1, MD_NONE);
    checkOutput("jal_malu", {32'd0, malu}, 64'h104);
    checkOutput("jal_mrn", {59'd0, mrn}, 64'd31);

    applyStimulus(1'b0, ALU_ADD, 32'd1, 32'd2, 32'd0, 32'd0, 5'd7, 1'b0, 1'b0, 1'b0, MD_NONE);

    mdu_op(MD_MULT, 32'hFFFFFFFD, 32'd4);
    checkOutput("mult_retire_mrn", {59'd0, mrn}, 64'd0);
    drain(MD_MFLO, n);
    checkOutput("mult_stall_cycles", 64'(n), 64'd32);
    checkOutput("mult_lo", {32'd0, malu}, 64'hFFFFFFF4);
    mdu_op(MD_MFHI, 32'd0, 32'd0);
    checkOutput("mult_hi", {32'd0, malu}, 64'hFFFFFFFF);

    mdu_op(MD_DIVU, 32'd100, 32'd0);
    alu_op(ALU_OR, 32'h0F, 32'hF0, 5'd2);
    drain(MD_MFLO, n);
    checkOutput("divu0_lo", {32'd0, malu}, 64'hFFFFFFFF);
    mdu_op(MD_MFHI, 32'd0, 32'd0);
    checkOutput("divu0_hi", {32'd0, malu}, 64'd100);

    mdu_op(MD_DIV, 32'hFFFFFFF9, 32'd2);
    drain(MD_MFLO, n);
    checkOutput("div_lo", {32'd0, malu}, 64'hFFFFFFFD);
    mdu_op(MD_MFHI, 32'd0, 32'd0);
    checkOutput("div_hi", {32'd0, malu}, 64'hFFFFFFFF);

    mdu_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    drain(MD_MFLO, n);
    checkOutput("divovf_lo", {32'd0, malu}, 64'h80000000);
    mdu_op(MD_MFHI, 32'd0, 32'd0);
    checkOutput("divovf_hi", {32'd0, malu}, 64'd0);

    alu_op(ALU_ADD, 32'h7FFFFFFF, 32'd1, 5'd4);
`ifdef PIPE_EXE_OVF_TRAP_EN
    checkOutput("ovf_moverf", {63'd0, moverf}, 64'd1);
    checkOutput("ovf_mrn", {59'd0, mrn}, 64'd0);
`else
    checkOutput("wrap_malu", {32'd0, malu}, 64'h80000000);
    checkOutput("wrap_mrn", {59'd0, mrn}, 64'd4);
`endif

    // Reset arriving ten cycles into a multiply
    mdu_op(MD_MULT, 32'd12345, 32'd678);
    for (int i = 0; i < 10; i++) alu_op(ALU_XOR, $urandom, $urandom, 5'd1);
    ein_valid = 1'b1; emdop = MD_MFHI; ejal = 1'b0;
    #1;
    checkOutput("pre_reset_estall", {63'd0, estall}, 64'd1);
    resetn = 1'b0;
    #1;
    checkOutput("reset_drop_estall", {63'd0, estall}, 64'd0);
    checkOutput("reset_mid_mvalid", {63'd0, mvalid}, 64'd0);
    m_left = 0; m_hi = '0; m_lo = '0;
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    mdu_op(MD_MFHI, 32'd0, 32'd0);
    checkOutput("post_reset_hi", {32'd0, malu}, 64'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      ra = rand_operand();
      rb = rand_operand();
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5:
          applyStimulus(1'b1, 4'($urandom_range(0, 11)), ra, rb, $urandom, $urandom,
                        5'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), MD_NONE);
        6: begin
          rmd = 3'($urandom_range(1, 4));
          mdu_op(rmd, ra, rb);
        end
        7: mdu_op(MD_MFHI, ra, rb);
        8: mdu_op(MD_MFLO, ra, rb);
        default:
          applyStimulus(1'b0, ALU_ADD, ra, rb, 32'd0, 32'd0, 5'd5, 1'b0, 1'b0, 1'b0, 3'($urandom_range(0, 6)));
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
